// File: rtl/mdu_iterative.sv
// Execute-stage multiply/divide unit: owns HI/LO and models multi-cycle latency with a busy counter.
// Define MDU_MADD_EN to enable madd/maddu (op 4/5) accumulating into {HI,LO}.
module mdu_iterative #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        hi_write,
  input  logic        lo_write,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_busy, w_busy_nxt;
  logic [31:0]        r_hi, w_hi_nxt;
  logic [31:0]        r_lo, w_lo_nxt;
  logic [31:0]        r_shadow_hi, w_shadow_hi_nxt;
  logic [31:0]        r_shadow_lo, w_shadow_lo_nxt;

  logic               w_op_valid;
  logic               w_op_signed;
  logic               w_op_div;
  logic               w_op_madd;

  logic [63:0]        w_mul_a;
  logic [63:0]        w_mul_b;
  logic [63:0]        w_prod;
  logic [31:0]        w_a_mag;
  logic [31:0]        w_b_mag;
  logic [31:0]        w_divisor;
  logic [31:0]        w_quo_mag;
  logic [31:0]        w_rem_mag;
  logic [31:0]        w_quo;
  logic [31:0]        w_rem;
  logic [63:0]        w_result;

  always_comb begin
    w_op_valid  = 1'b0;
    w_op_signed = 1'b0;
    w_op_div    = 1'b0;
    w_op_madd   = 1'b0;
    case (op)
      3'd0: begin w_op_valid = 1'b1; w_op_signed = 1'b1; end
      3'd1: begin w_op_valid = 1'b1; end
      3'd2: begin w_op_valid = 1'b1; w_op_signed = 1'b1; w_op_div = 1'b1; end
      3'd3: begin w_op_valid = 1'b1; w_op_div = 1'b1; end
`ifdef MDU_MADD_EN
      3'd4: begin w_op_valid = 1'b1; w_op_signed = 1'b1; w_op_madd = 1'b1; end
      3'd5: begin w_op_valid = 1'b1; w_op_madd = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Sign-extending both operands to 64 bits lets one multiplier serve signed and unsigned ops.
  assign w_mul_a = {(w_op_signed ? {32{a[31]}} : 32'h0), a};
  assign w_mul_b = {(w_op_signed ? {32{b[31]}} : 32'h0), b};
  assign w_prod  = w_mul_a * w_mul_b;

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  assign w_a_mag   = (w_op_signed && a[31]) ? (~a + 32'd1) : a;
  assign w_b_mag   = (w_op_signed && b[31]) ? (~b + 32'd1) : b;
  assign w_divisor = (w_b_mag == 32'h0) ? 32'd1 : w_b_mag;
  assign w_quo_mag = w_a_mag / w_divisor;
  assign w_rem_mag = w_a_mag % w_divisor;
  assign w_quo     = (w_op_signed && (a[31] ^ b[31])) ? (~w_quo_mag + 32'd1) : w_quo_mag;
  assign w_rem     = (w_op_signed && a[31]) ? (~w_rem_mag + 32'd1) : w_rem_mag;

  always_comb begin
    w_result = {r_hi, r_lo};
    if (w_op_div) begin
      if (b != 32'h0) begin
        w_result = {w_rem, w_quo};
      end
    end else if (w_op_madd) begin
      w_result = {r_hi, r_lo} + w_prod;
    end else if (w_op_valid) begin
      w_result = w_prod;
    end
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_busy_nxt      = r_busy;
    w_hi_nxt        = r_hi;
    w_lo_nxt        = r_lo;
    w_shadow_hi_nxt = r_shadow_hi;
    w_shadow_lo_nxt = r_shadow_lo;
    case (r_state)
      S_IDLE: begin
        if (!req) begin
          if (start) begin
            // An accepted start always swallows a concurrent mthi/mtlo, even for an undefined op.
            if (w_op_valid) begin
              w_shadow_hi_nxt = w_result[63:32];
              w_shadow_lo_nxt = w_result[31:0];
              w_cnt_nxt       = w_op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              w_busy_nxt      = 1'b1;
              w_state_nxt     = S_BUSY;
            end
          end else begin
            if (hi_write) w_hi_nxt = a;
            if (lo_write) w_lo_nxt = a;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == CNT_W'(1)) begin
          w_hi_nxt    = r_shadow_hi;
          w_lo_nxt    = r_shadow_lo;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_hi        <= 32'h0;
      r_lo        <= 32'h0;
      r_shadow_hi <= 32'h0;
      r_shadow_lo <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= w_busy_nxt;
      r_hi        <= w_hi_nxt;
      r_lo        <= w_lo_nxt;
      r_shadow_hi <= w_shadow_hi_nxt;
      r_shadow_lo <= w_shadow_lo_nxt;
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Execute-stage multiply/divide unit.
- Consumes the start, operation-select and HI/LO-write controls decoded in D and carried to E.
- Owns the architectural HI/LO registers and models multi-cycle latency with a busy counter.
- mfhi/mflo read hi/lo combinationally in E.
- The hazard unit stalls D on any MD/MF/MT instruction while (start | busy).

Parameters:
- MULT_CYCLES, 5, cycles from accepted start until HI/LO updated for mult/multu (madd/maddu when enabled).
- DIV_CYCLES, 10, cycles from accepted start until HI/LO updated for div/divu.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- req  input  1  exception/interrupt flush this cycle; suppresses start/hi_write/lo_write
- start  input  1  begin operation (MDU_Start from decode)
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu (4/5 only with feature)
- hi_write  input  1  mthi: HI <= a
- lo_write  input  1  mtlo: LO <= a
- a  input  32  rs operand (forwarded)
- b  input  32  rt operand (forwarded)
- busy  output  1  operation in flight (registered)
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- One clock (clk); reset synchronous, active-high.
- Reset: state IDLE, counter 0, busy 0, hi 0, lo 0, shadow regs 0. Reset mid-operation abandons the operation; HI/LO still read 0.
- FSM IDLE:
  - start & ~req: latch op results into shadow_hi/shadow_lo; counter <= MULT_CYCLES or DIV_CYCLES per op; busy <= 1; go to BUSY.
  - start & req: ignored, stays IDLE.
- FSM BUSY:
  - Counter decrements each cycle.
  - On the cycle counter==1: hi <= shadow_hi, lo <= shadow_lo, busy <= 0, counter <= 0, go to IDLE.
  - Total: busy high for exactly N cycles after the start edge. HI/LO show the result on the first cycle busy reads 0.
- req never cancels an in-flight operation. Only reset does.
- start while BUSY: ignored; no restart. The hazard unit guarantees this does not occur. The bench checks it is harmless.
- hi_write/lo_write:
  - Take effect next edge only when IDLE and ~req.
  - Ignored while BUSY.
  - If both are high, both write a.
  - If asserted together with start in IDLE, start takes priority and the write is dropped.
- Arithmetic:
  - mult: {hi,lo} = $signed(a)*$signed(b), full 64-bit.
  - multu: unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - divu: unsigned quotient and remainder.
  - 0x80000000 div 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (b==0, div/divu): op still occupies DIV_CYCLES with busy high; HI/LO left unchanged at completion.
- Undefined op codes (6, 7, or 4/5 without feature) with start: treated as no-op. No busy, no state change.
- Outputs hi/lo/busy are pure register outputs; no combinational path from inputs.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 4 gives {hi,lo} <= {hi,lo} + signed 64-bit product (madd).
  - op 5 gives {hi,lo} <= {hi,lo} + unsigned product (maddu).
  - Both use MULT_CYCLES.
  - The accumulation base is the HI/LO value at the accepted start edge; 64-bit wrap-around, no overflow flag.
- Undefined: op 4/5 are no-ops as above.

Test Plan:
- Reset then start op=0, a=0xFFFFFFFE(-2), b=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Start op=1, a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- Start op=2, a=0xFFFFFFF9(-7), b=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then op=3, b=0 with hi/lo preset → busy 10 cycles, hi/lo unchanged.
- hi_write a=0x12345678 in IDLE, then lo_write a=0x9ABCDEF0 → hi/lo updated next edge. Same writes issued while busy, and with req=1 → no change.
- start op=0 with req=1 → busy stays 0, hi/lo unchanged. Start accepted, then req pulsed at cycle 2 → op completes normally at cycle 5. Reset asserted at cycle 3 of a div → busy=0, hi=lo=0 next edge.
- (MDU_MADD_EN) hi=0, lo=0xFFFFFFFF, op=5, a=1, b=1 → hi=0x00000001, lo=0x00000000 after 5 cycles. Without macro, same stimulus → busy stays 0, no change.
